// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the sequential signed divider: state encoding,
// widths and the 32-bit adder with carry-in used by the datapath.
package div_sequencer_pkg;

    localparam int DATA_W   = 32;
    localparam int ITER_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Returns {carry_out, sum}; subtraction is a + ~b with cin = 1.
    function automatic logic [DATA_W:0] add32(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b,
        input logic              cin
    );
        return {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    endfunction

    function automatic logic [DATA_W-1:0] negate32(input logic [DATA_W-1:0] x);
        return DATA_W'(add32(~x, '0, 1'b1));
    endfunction

endpackage

// File: rtl/div_sequencer_operand_magnitude.sv
// Combinational magnitude and zero detect for one signed operand.
module operand_magnitude
    import div_sequencer_pkg::*;
(
    input  logic [DATA_W-1:0] i_x,
    output logic [DATA_W-1:0] o_mag,
    output logic              o_zero
);

    assign o_mag  = i_x[DATA_W-1] ? negate32(i_x) : i_x;
    assign o_zero = (i_x == '0);

endmodule

// File: rtl/div_sequencer.sv
// Sequential signed divider: one restoring step per clock on operand
// magnitudes, followed by a sign-fix cycle and a one-cycle result pulse.
module div_sequencer
    import div_sequencer_pkg::*;
#(
    parameter int ITER = ITER_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ctrl_DIV,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    output logic [DATA_W-1:0] data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              busy
);

    localparam int               CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(ITER - 1);

    state_t              r_state, w_next;
    logic [DATA_W:0]     r_rem;
    logic [DATA_W-1:0]   r_quo, r_dvs, r_result;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sign_a, r_sign_b, r_zero_a, r_zero_b, r_exc;

    logic [DATA_W-1:0]   w_mag_a, w_mag_b, w_neg;
    logic                w_zero_a, w_zero_b;
    logic [DATA_W:0]     w_rem_sh, w_sub, w_trial;
    logic                w_fits, w_neg_en, w_ovf;

    operand_magnitude u_mag_a (.i_x(data_operandA), .o_mag(w_mag_a), .o_zero(w_zero_a));
    operand_magnitude u_mag_b (.i_x(data_operandB), .o_mag(w_mag_b), .o_zero(w_zero_b));

    // 33-bit trial subtract: the low 32 bits go through the adder, the top
    // bit folds in the all-ones extension of ~{0,|B|} plus the adder carry.
    assign w_rem_sh = {r_rem[DATA_W-1:0], r_quo[DATA_W-1]};
    assign w_sub    = add32(w_rem_sh[DATA_W-1:0], ~r_dvs, 1'b1);
    assign w_trial  = {~(w_rem_sh[DATA_W] ^ w_sub[DATA_W]), w_sub[DATA_W-1:0]};
    assign w_fits   = ~w_trial[DATA_W];

    assign w_neg    = negate32(r_quo);
    assign w_neg_en = (r_sign_a ^ r_sign_b) & ~r_zero_a & (r_quo != '0);
    // Only MIN / -1 yields a same-sign quotient that does not fit in 31 bits.
    assign w_ovf    = ~(r_sign_a ^ r_sign_b) & r_quo[DATA_W-1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // NOTE: every output of this block gets a default before the case, so no latch can form.
    always_comb begin
        w_next         = r_state;
        busy           = 1'b0;
        data_resultRDY = 1'b0;
        case (r_state)
            IDLE: ;
            RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST) w_next = FIX;
            end
            FIX: begin
                busy   = 1'b1;
                w_next = DONE;
            end
            DONE: begin
                data_resultRDY = 1'b1;
                w_next         = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (ctrl_DIV) w_next = w_zero_b ? DONE : RUN;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rem    <= '0;
            r_quo    <= '0;
            r_dvs    <= '0;
            r_cnt    <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_zero_a <= 1'b0;
            r_zero_b <= 1'b0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (ctrl_DIV) begin
            r_sign_a <= data_operandA[DATA_W-1];
            r_sign_b <= data_operandB[DATA_W-1];
            r_zero_a <= w_zero_a;
            r_zero_b <= w_zero_b;
            r_quo    <= w_mag_a;
            r_dvs    <= w_mag_b;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_exc    <= w_zero_b;
        end else begin
            case (r_state)
                RUN: begin
                    r_rem <= w_fits ? w_trial : w_rem_sh;
                    r_quo <= {r_quo[DATA_W-2:0], w_fits};
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FIX: begin
                    r_result <= w_neg_en ? w_neg : r_quo;
                    r_exc    <= w_ovf | r_zero_b;
                end
                default: ;
            endcase
        end
    end

    assign data_result    = r_result;
    assign data_exception = r_exc;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: expected quotient, flag and latency are
// queued at each start and compared when data_resultRDY pulses.
module tb_div_sequencer;

    localparam int ITER = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    div_sequencer #(.ITER(ITER)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          lat;
        int          t0;
    } exp_t;

    exp_t q[$];
    int   cyc       = 0;
    int   rdy_count = 0;
    int   n_checks  = 0;
    int   n_errors  = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: truncating signed division with the two special cases.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   sa, sb;
        sa = int'(a);
        sb = int'(b);
        e.t0 = 0;
        if (b == 32'd0) begin
            e.res = '0; e.exc = 1'b1; e.lat = 0;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            e.res = 32'h8000_0000; e.exc = 1'b1; e.lat = ITER + 1;
        end else begin
            e.res = 32'(sa / sb); e.exc = 1'b0; e.lat = ITER + 1;
        end
        return e;
    endfunction

    always @(negedge clock) begin
        if (data_resultRDY) begin
            rdy_count++;
            if (q.size() == 0) begin
                check("spurious_rdy", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("result", data_result, e.res);
                check("exception", {31'd0, data_exception}, {31'd0, e.exc});
                check("latency", 32'(cyc - e.t0), 32'(e.lat));
            end
        end
    end

    // A start supersedes any pending operation; E0 is the next posedge.
    task automatic start_op(input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV      = 1'b1;
        e    = model(a, b);
        e.t0 = cyc + 1;
        q.delete();
        q.push_back(e);
        @(posedge clock);
        #1;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clock);
            n++;
        end
        if (q.size() != 0) begin
            check("timeout", 32'd0, 32'd1);
            q.delete();
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b);
        start_op(a, b);
        wait_idle(100);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int saved;

        repeat (3) @(posedge clock);
        #1;
        check("reset_result", data_result, 32'd0);
        check("reset_exc", {31'd0, data_exception}, 32'd0);
        check("reset_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b0;

        // Basic and sign combinations.
        run_op(32'd100, 32'd7);
        run_op(-32'sd100, 32'd7);
        run_op(32'd100, -32'sd7);
        run_op(-32'sd100, -32'sd7);

        // Divide by zero: result in the cycle after E0, never busy.
        start_op(32'd7, 32'd0);
        check("div0_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        check("div0_busy_done", {31'd0, busy}, 32'd0);
        wait_idle(10);

        // Overflow and min-int boundaries, zero dividend.
        run_op(32'h8000_0000, 32'hFFFF_FFFF);
        run_op(32'h8000_0000, 32'd2);
        run_op(32'd0, 32'd5);
        run_op(32'h7FFF_FFFF, 32'd1);

        // Busy during RUN and hold of result after DONE.
        start_op(32'd81, 32'd9);
        check("busy_run", {31'd0, busy}, 32'd1);
        wait_idle(100);
        repeat (3) @(negedge clock);
        check("result_hold", data_result, 32'd9);

        // Restart at iteration 10: only the second operation reports.
        start_op(32'd1000, 32'd3);
        repeat (9) @(posedge clock);
        saved = rdy_count;
        start_op(32'd50, 32'd5);
        wait_idle(100);
        repeat (2) @(negedge clock);
        check("restart_single_rdy", 32'(rdy_count - saved), 32'd1);

        // Reset at iteration 20 discards the operation.
        start_op(32'd1000, 32'd3);
        repeat (20) @(posedge clock);
        #2;
        check("busy_pre_reset", {31'd0, busy}, 32'd1);
        saved = rdy_count;
        reset = 1'b1;
        q.delete();
        #1;
        check("rst_result", data_result, 32'd0);
        check("rst_exc", {31'd0, data_exception}, 32'd0);
        check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        check("reset_no_rdy", 32'(rdy_count - saved), 32'd0);
        run_op(32'd9, 32'd3);

        // A few random operands.
        for (int i = 0; i < 6; i++) begin
            run_op($urandom, $urandom_range(1, 5000) * ((i % 2 == 0) ? 1 : -1));
        end

        repeat (2) @(negedge clock);
        check("queue_empty", 32'(q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have ports: clock, input, 1, rising-edge system clock.
REQ-002 SHALL have ports: reset, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports: ctrl_DIV, input, 1, start pulse that samples the operands.
REQ-004 SHALL have ports: data_operandA, input, 32, signed two's-complement dividend.
REQ-005 SHALL have ports: data_operandB, input, 32, signed two's-complement divisor.
REQ-006 SHALL have ports: data_result, output, 32, signed quotient, truncated toward zero.
REQ-007 SHALL have ports: data_exception, output, 1, divide-by-zero or overflow flag.
REQ-008 SHALL have ports: data_resultRDY, output, 1, one-cycle pulse marking a valid result and flag.
REQ-009 SHALL have ports: busy, output, 1, high while a division is in progress.
REQ-010 SHALL have parameter ITER, default 32, meaning the number of quotient iterations (one per bit).

Function
REQ-011 SHALL implement FSM states IDLE, RUN, FIX, DONE.
REQ-012 At an edge E0 with ctrl_DIV=1, SHALL latch both operands, the sign bits A[31] and B[31], and the zero flags of both operands.
- This applies in any state; a start while busy aborts the current operation and restarts it.
REQ-013 At E0 with nonzero divisor:
- SHALL load the magnitudes |A| and |B| into the dividend and divisor registers (value if bit31=0, else ~x+1).
- SHALL clear the 33-bit partial remainder and the iteration counter.
- SHALL enter RUN.
REQ-014 In RUN, each edge SHALL perform one restoring step.
- Shift {R,Q} left by 1.
- Form T = R − |B| (33-bit).
- If T ≥ 0: R=T and Q[0]=1; else R is unchanged and Q[0]=0.
- The counter increments once per step.
REQ-015 After the ITER-th RUN step (edge E32), SHALL go to FIX.
REQ-016 At the FIX edge (E33):
- data_result SHALL be Q, negated if A[31]^B[31] and Q≠0.
- The FSM SHALL enter DONE.
REQ-017 data_resultRDY SHALL be high exactly during DONE, which is the cycle following E33 (34 edges after E0 for nonzero divisor), and DONE SHALL return to IDLE at the next edge.
REQ-018 A zero divisor at E0:
- SHALL skip RUN and FIX.
- SHALL set data_result=0 and data_exception=1 and enter DONE at E0.
- data_resultRDY SHALL therefore be high during the cycle following E0.
REQ-019 A dividend of 0x80000000 with a divisor of 0xFFFFFFFF:
- SHALL produce data_result=0x80000000 and data_exception=1 via the normal 34-edge path.
REQ-020 A zero dividend with a nonzero divisor SHALL yield data_result=0 and data_exception=0, with no negative-zero handling.
REQ-021 data_result and data_exception SHALL hold their last values until the next E0, where both clear to 0.
REQ-022 busy SHALL be high in RUN and FIX and low in IDLE and DONE.
REQ-023 ctrl_DIV asserted during DONE SHALL start a new operation.
- The current data_resultRDY pulse still completes in that cycle.
REQ-024 Operand inputs SHALL be ignored in every cycle except E0.

Reset
REQ-025 reset=1 SHALL immediately force:
- state to IDLE;
- all data registers and the counter to 0;
- data_result=0, data_exception=0, data_resultRDY=0, busy=0.
REQ-026 A reset asserted mid-operation SHALL discard that operation, and no data_resultRDY SHALL follow it.
REQ-027 The first start after reset deassertion SHALL behave identically to a start from IDLE.

Structure
REQ-028 A shared package SHALL hold the state encoding (2-bit localparams IDLE=0, RUN=1, FIX=2, DONE=3), the data width 32, and ITER.
REQ-029 SHALL instantiate one sub-module, operand_magnitude, twice.
- Combinational; input 32-bit x; outputs |x| (two's-complement negate when x[31]) and a zero flag.
REQ-030 Restoring-step subtraction and final negation SHALL use the team's 32-bit adder with carry-in.

Verification
REQ-031 100 / 7 -> data_result=14, exception=0, data_resultRDY high exactly 34 edges after the start edge.
REQ-032 −100 / 7 -> data_result=0xFFFFFFF2; and 100 / −7 -> 0xFFFFFFF2; and −100 / −7 -> 14.
REQ-033 7 / 0 -> data_result=0, exception=1, data_resultRDY in the cycle after the start edge, busy never high.
REQ-034 0x80000000 / 0xFFFFFFFF -> data_result=0x80000000, exception=1; and 0x80000000 / 2 -> 0xC0000000, exception=0.
REQ-035 Start 1000/3, then restart at iteration 10 with 50/5 -> a single data_resultRDY with result 10, 34 edges after the second start.
REQ-036 Start 1000/3, pulse reset at iteration 20 -> all outputs 0 at once, no data_resultRDY; a subsequent 9/3 -> 3.
